sequenciador_programa: RTL and testbench



---
 rtl/sequenciador_programa.sv | 152 +++++++++++++++
 tb/tb_sequenciador_programa.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_programa.sv
// Instruction sequencer feeding processador_multiciclo: small program memory,
// one-cycle Run pulse per instruction, immediate word for mvi, Done/watchdog tracking.
module sequenciador_programa #(
    parameter int          ADDR_W    = 5,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter int          TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic              Prog_we,
    input  logic [ADDR_W-1:0] Prog_addr,
    input  logic [15:0]       Prog_data,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [2:0]        Dbg_state
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam int                WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // Handshake: Run is high for exactly one cycle per issued instruction;
    // Done is only honoured while waiting for that instruction to complete.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       din_q, din_d;
    logic              run_q, run_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              end_q, end_d;

    logic [15:0]       mem [DEPTH];
    logic [15:0]       word_cur, word_nxt;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W:0]   pc_sum;
    logic              is_mvi, idle_like;

    assign pc_plus1  = pc_q + ADDR_W'(1);
    assign word_cur  = mem[pc_q];
    assign word_nxt  = mem[pc_plus1];
    assign is_mvi    = (word_cur[8:6] == 3'b001);
    // Extra carry bit records wrap past the last address (end flag).
    assign pc_sum    = {1'b0, pc_q} + (is_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR);

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge Clock) begin
        if (Prog_we && idle_like) begin
            mem[Prog_addr] <= Prog_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            wd_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            run_q   <= run_d;
            wd_q    <= wd_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        run_d   = 1'b0;
        wd_d    = wd_q;
        end_d   = end_q;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                din_d = '0;
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    end_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (word_cur == HALT_WORD) begin
                    state_d = S_HALTED;
                    din_d   = '0;
                end else if (is_mvi && (pc_q == LAST_ADDR)) begin
                    state_d = S_ERROR;
                    din_d   = '0;
                end else begin
                    state_d = S_ISSUE;
                    din_d   = word_cur;
                    run_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                // Immediate replaces the instruction on the edge that drops Run.
                wd_d    = '0;
                pc_d    = pc_sum[ADDR_W-1:0];
                end_d   = pc_sum[ADDR_W];
                state_d = S_WAIT;
                if (is_mvi) begin
                    din_d = word_nxt;
                end
            end
            S_WAIT: begin
                if (Done) begin
                    state_d = end_q ? S_HALTED : S_FETCH;
                    if (end_q) begin
                        din_d = '0;
                    end
                end else if (wd_q == WD_MAX) begin
                    state_d = S_ERROR;
                    din_d   = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DIN       = din_q;
    assign Run       = run_q;
    assign PC        = pc_q;
    assign Busy      = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign Halted    = (state_q == S_HALTED);
    assign Error     = (state_q == S_ERROR);
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Directed bench for sequenciador_programa with a simple processor model
// (Done 2 cycles after Run, 3 for mvi) and a DIN scoreboard.
module tb_sequenciador_programa;

    logic        Clock = 1'b0;
    logic        Resetn, Start, Done, Prog_we;
    logic [4:0]  Prog_addr;
    logic [15:0] Prog_data;
    logic [15:0] DIN;
    logic        Run, Busy, Halted, Error;
    logic [4:0]  PC;
    logic [2:0]  dbg_state;

    int          errors = 0;
    int          checks = 0;
    int          run_cnt = 0;
    int          cyc = 0;
    int          first_run = -1;
    int          last_run = -1;
    logic        run_prev = 1'b0;
    bit          proc_en = 1'b0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] w0, w1, w2;
        int          runs;
        logic [4:0]  pc;
        logic [15:0] d0, d1;
    } vec_t;
    vec_t vecs[6];

    always #5 Clock = ~Clock;

    sequenciador_programa dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .Done      (Done),
        .Prog_we   (Prog_we),
        .Prog_addr (Prog_addr),
        .Prog_data (Prog_data),
        .DIN       (DIN),
        .Run       (Run),
        .PC        (PC),
        .Busy      (Busy),
        .Halted    (Halted),
        .Error     (Error),
        .Dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: logs DIN on each Run cycle and on the cycle after it.
    always @(negedge Clock) begin
        cyc++;
        if (run_prev) got_q.push_back(DIN);
        if (Run) begin
            run_cnt++;
            got_q.push_back(DIN);
            if (first_run < 0) first_run = cyc;
            last_run = cyc;
        end
        run_prev = Run;
        if (!Resetn) check("run_in_reset", {31'b0, Run}, 32'd0);
    end

    // Processor model.
    initial begin
        int lat;
        Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (proc_en && Run && Resetn) begin
                lat = (DIN[8:6] == 3'b001) ? 3 : 2;
                repeat (lat) @(negedge Clock);
                Done = 1'b1;
                @(negedge Clock);
                Done = 1'b0;
            end
        end
    end

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        Prog_we = 1'b1;
        Prog_addr = a;
        Prog_data = d;
        @(negedge Clock);
        Prog_we = 1'b0;
    endtask

    task automatic load_prog1();
        load(5'd0, 16'h0040);
        load(5'd1, 16'h0005);
        load(5'd2, 16'h0008);
        load(5'd3, 16'h0081);
        load(5'd4, 16'hFFFF);
    endtask

    task automatic set_exp_prog1();
        exp_q = '{16'h0040, 16'h0005, 16'h0008, 16'h0008, 16'h0081, 16'h0081};
    endtask

    task automatic start_prog();
        got_q.delete();
        run_cnt = 0;
        first_run = -1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(Halted || Error) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check("wait_end", {31'b0, Halted || Error}, 32'd1);
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (!Run && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check("wait_run", {31'b0, Run}, 32'd1);
    endtask

    task automatic compare_q(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_din%0d", name, i), {16'b0, got_q[i]}, {16'b0, exp_q[i]});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        vecs[0] = '{16'h0008, 16'hFFFF, 16'h0000, 1, 5'd1, 16'h0008, 16'h0008};
        vecs[1] = '{16'h0040, 16'h1234, 16'hFFFF, 1, 5'd2, 16'h0040, 16'h1234};
        vecs[2] = '{16'hFFFF, 16'h0008, 16'h0008, 0, 5'd0, 16'h0000, 16'h0000};
        vecs[3] = '{16'h0081, 16'h0040, 16'h0007, 2, 5'd3, 16'h0081, 16'h0081};
        vecs[4] = '{16'h01C0, 16'h0140, 16'h0008, 3, 5'd3, 16'h01C0, 16'h01C0};
        vecs[5] = '{16'hFE40, 16'hFFFF, 16'hFFFF, 1, 5'd2, 16'hFE40, 16'hFFFF};

        Resetn = 1'b0; Start = 1'b0; Prog_we = 1'b0; Prog_addr = '0; Prog_data = '0;
        repeat (2) @(negedge Clock);
        check("rst_din", {16'b0, DIN}, 32'd0);
        check("rst_run", {31'b0, Run}, 32'd0);
        check("rst_pc", {27'b0, PC}, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_halted", {31'b0, Halted}, 32'd0);
        check("rst_error", {31'b0, Error}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);
        proc_en = 1'b1;

        // Write and Start on the same edge: FETCH must see the new word.
        load(5'd0, 16'hFFFF);
        load(5'd1, 16'hFFFF);
        Prog_we = 1'b1; Prog_addr = 5'd0; Prog_data = 16'h0008; Start = 1'b1;
        @(negedge Clock);
        Prog_we = 1'b0; Start = 1'b0;
        check("fetch_busy", {31'b0, Busy}, 32'd1);
        check("fetch_run", {31'b0, Run}, 32'd0);
        @(negedge Clock);
        check("issue_run", {31'b0, Run}, 32'd1);
        check("issue_din", {16'b0, DIN}, 32'h0008);
        wait_end(50);
        check("we_start_pc", {27'b0, PC}, 32'd1);
        check("we_start_halted", {31'b0, Halted}, 32'd1);

        // Table of short programs, each followed by a halt word at address 3.
        for (int v = 0; v < 6; v++) begin
            load(5'd0, vecs[v].w0);
            load(5'd1, vecs[v].w1);
            load(5'd2, vecs[v].w2);
            load(5'd3, 16'hFFFF);
            start_prog();
            wait_end(100);
            check($sformatf("vec%0d_runs", v), run_cnt, vecs[v].runs);
            check($sformatf("vec%0d_pc", v), {27'b0, PC}, {27'b0, vecs[v].pc});
            check($sformatf("vec%0d_halted", v), {31'b0, Halted}, 32'd1);
            check($sformatf("vec%0d_error", v), {31'b0, Error}, 32'd0);
            check($sformatf("vec%0d_din0", v), {16'b0, DIN}, 32'd0);
            if (vecs[v].runs > 0 && got_q.size() >= 2) begin
                check($sformatf("vec%0d_d0", v), {16'b0, got_q[0]}, {16'b0, vecs[v].d0});
                check($sformatf("vec%0d_d1", v), {16'b0, got_q[1]}, {16'b0, vecs[v].d1});
            end
        end

        // Reference program.
        load_prog1();
        set_exp_prog1();
        start_prog();
        wait_end(100);
        check("p1_runs", run_cnt, 3);
        check("p1_pc", {27'b0, PC}, 32'd4);
        check("p1_halted", {31'b0, Halted}, 32'd1);
        compare_q("p1");

        // Watchdog: no Done after the first Run.
        proc_en = 1'b0;
        start_prog();
        wait_run(10);
        n = 0;
        while (!Error && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("wd_cycles", n, 17);
        check("wd_error", {31'b0, Error}, 32'd1);
        check("wd_busy", {31'b0, Busy}, 32'd0);
        check("wd_din", {16'b0, DIN}, 32'd0);
        check("wd_halted", {31'b0, Halted}, 32'd0);
        check("wd_runs", run_cnt, 1);
        proc_en = 1'b1;

        // Asynchronous reset during WAIT of the second instruction.
        start_prog();
        n = 0;
        while (run_cnt < 2 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("rst2_second_run", run_cnt, 2);
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("rst2_din", {16'b0, DIN}, 32'd0);
        check("rst2_run", {31'b0, Run}, 32'd0);
        check("rst2_pc", {27'b0, PC}, 32'd0);
        check("rst2_busy", {31'b0, Busy}, 32'd0);
        check("rst2_halted", {31'b0, Halted}, 32'd0);
        check("rst2_error", {31'b0, Error}, 32'd0);
        repeat (5) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        start_prog();
        wait_end(100);
        check("rst2_runs", run_cnt, 3);
        check("rst2_end_pc", {27'b0, PC}, 32'd4);
        compare_q("rst2");

        // Write and Start during WAIT are ignored.
        start_prog();
        wait_run(10);
        @(negedge Clock);
        Prog_we = 1'b1; Prog_addr = 5'd3; Prog_data = 16'hFFFF; Start = 1'b1;
        @(negedge Clock);
        Prog_we = 1'b0; Start = 1'b0;
        wait_end(100);
        check("ign_runs", run_cnt, 3);
        check("ign_pc", {27'b0, PC}, 32'd4);
        compare_q("ign");

        // Same write while HALTED is accepted.
        load(5'd3, 16'hFFFF);
        start_prog();
        wait_end(100);
        check("hwr_runs", run_cnt, 2);
        check("hwr_pc", {27'b0, PC}, 32'd3);
        check("hwr_halted", {31'b0, Halted}, 32'd1);

        // Whole memory of mv, no halt word: wrap ends the program.
        for (int i = 0; i < 32; i++) load(5'(i), 16'h0008);
        start_prog();
        wait_end(300);
        check("all_runs", run_cnt, 32);
        check("all_halted", {31'b0, Halted}, 32'd1);
        check("all_error", {31'b0, Error}, 32'd0);
        check("all_pc", {27'b0, PC}, 32'd0);
        check("all_period", last_run - first_run, 124);

        // mvi in the last word has no immediate.
        load(5'd31, 16'h0040);
        start_prog();
        wait_end(300);
        check("last_mvi_error", {31'b0, Error}, 32'd1);
        check("last_mvi_halted", {31'b0, Halted}, 32'd0);
        check("last_mvi_runs", run_cnt, 31);
        check("last_mvi_pc", {27'b0, PC}, 32'd31);
        check("last_mvi_busy", {31'b0, Busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
